// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: ID operands, redirect, MEM handshake,
// per-stage stall/flush vectors and performance counters.
interface pipe_hazard_ctrl_if #(
    parameter int NUM_STAGES = 5,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_is_load;
    logic                  take_branch;
    logic                  mem_req;
    logic                  mem_ready;
    logic [NUM_STAGES-1:0] stall;
    logic [NUM_STAGES-1:0] flush;
    logic                  load_use_hazard;
    logic                  issue;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_events;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output id_rd, id_is_load, take_branch, mem_req, mem_ready,
        input  stall, flush, load_use_hazard, issue,
        input  stall_cycles, flush_events
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  id_rd, id_is_load, take_branch, mem_req, mem_ready,
        output stall, flush, load_use_hazard, issue,
        output stall_cycles, flush_events
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load scoreboard, MEM ready stall,
// branch flush, per-stage stall/flush vectors, saturating counters.
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int BR_STAGE   = 2,
    parameter int MEM_STAGE  = 3,
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 32
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int NREG = 1 << REG_ADDR_W;
    localparam int SB_W = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;

    localparam logic [NUM_STAGES-1:0] MS_STALL =
        NUM_STAGES'((1 << MEM_STAGE) - 1);
    localparam logic [NUM_STAGES-1:0] MS_FLUSH =
        NUM_STAGES'(1 << MEM_STAGE);
    localparam logic [NUM_STAGES-1:0] BR_FLUSH =
        NUM_STAGES'((1 << BR_STAGE) - 1);
    localparam logic [NUM_STAGES-1:0] HZ_STALL = NUM_STAGES'(3);
    localparam logic [NUM_STAGES-1:0] HZ_FLUSH = NUM_STAGES'(2);

    logic                  w_mem_stall;
    logic                  w_hazard;
    logic                  w_issue;
    logic                  w_set;
    logic                  w_br_acc;
    logic                  w_luh;
    logic [NREG-1:0]       w_busy;
    logic [NUM_STAGES-1:0] w_stall;
    logic [NUM_STAGES-1:0] w_flush;
    logic [CNT_W-1:0]      r_stall_cycles;
    logic [CNT_W-1:0]      r_flush_events;

    assign w_mem_stall = bus.mem_req & ~bus.mem_ready;

    assign w_hazard = bus.id_valid &
        ((bus.id_uses_rs1 & w_busy[bus.id_rs1]) |
         (bus.id_uses_rs2 & w_busy[bus.id_rs2]));

    assign w_br_acc = bus.take_branch & ~w_mem_stall;

    assign w_issue = ~rst & bus.id_valid & ~w_mem_stall &
                     ~bus.take_branch & ~w_hazard;

    assign w_set = w_issue & bus.id_is_load & (bus.id_rd != '0);

    always_comb begin
        w_stall = '0;
        w_flush = '0;
        w_luh   = 1'b0;
        priority case (1'b1)
            rst: w_flush = '1;
            w_mem_stall: begin
                w_stall = MS_STALL;
                w_flush = MS_FLUSH;
            end
            bus.take_branch: w_flush = BR_FLUSH;
            w_hazard: begin
                w_stall = HZ_STALL;
                w_flush = HZ_FLUSH;
                w_luh   = 1'b1;
            end
            default: ;
        endcase
    end

    generate
        if (LOAD_LAT > 0) begin : g_sb
            logic [SB_W-1:0] r_cnt [NREG];

            // Entries freeze while MEM is waiting; a new load wins over decrement.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
                end else if (!w_mem_stall) begin
                    for (int i = 0; i < NREG; i++) begin
                        if (i == 0)
                            r_cnt[i] <= '0;
                        else if (w_set && bus.id_rd == REG_ADDR_W'(i))
                            r_cnt[i] <= SB_W'(LOAD_LAT);
                        else if (r_cnt[i] != '0)
                            r_cnt[i] <= r_cnt[i] - SB_W'(1);
                    end
                end
            end

            always_comb begin
                w_busy = '0;
                for (int i = 1; i < NREG; i++)
                    w_busy[i] = (r_cnt[i] != '0);
            end
        end else begin : g_nosb
            assign w_busy = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (w_stall[0] && r_stall_cycles != '1)
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            if (w_br_acc && r_flush_events != '1)
                r_flush_events <= r_flush_events + CNT_W'(1);
        end
    end

    assign bus.stall           = w_stall;
    assign bus.flush           = w_flush;
    assign bus.load_use_hazard = w_luh;
    assign bus.issue           = w_issue;
    assign bus.stall_cycles    = r_stall_cycles;
    assign bus.flush_events    = r_flush_events;
endmodule
